// File: rtl/key_event_pkg.sv
// Shared types and default parameter values for the key event decoder.
package key_event_pkg;

    typedef enum logic [1:0] {
        LOCK    = 2'd0,
        IDLE    = 2'd1,
        PRESSED = 2'd2,
        LONG    = 2'd3
    } key_state_t;

    localparam int unsigned DEF_LONG_CYCLES   = 1000;
    localparam int unsigned DEF_REPEAT_CYCLES = 250;
    localparam int unsigned DEF_CNT_W         = 16;

endpackage

// File: rtl/key_event_decoder_if.sv
// Key level in, single-cycle key events out; master drives clean, slave produces events.
interface key_event_decoder_if;
    logic clean;
    logic press;
    logic long_press;
    logic repeat_evt;
    logic release_evt;
    logic release_long;
    logic held;

    modport master (
        output clean,
        input  press, long_press, repeat_evt, release_evt, release_long, held
    );

    modport slave (
        input  clean,
        output press, long_press, repeat_evt, release_evt, release_long, held
    );
endinterface

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into press / long-press / repeat / release pulses.
// A key already held when reset is released is ignored until it is let go.
module key_event_decoder
    import key_event_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input logic                clk,
    input logic                rst,
    key_event_decoder_if.slave bus
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    key_state_t       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= LOCK;
            cnt              <= '0;
            bus.press        <= 1'b0;
            bus.long_press   <= 1'b0;
            bus.repeat_evt   <= 1'b0;
            bus.release_evt  <= 1'b0;
            bus.release_long <= 1'b0;
            bus.held         <= 1'b0;
        end else begin
            bus.press       <= 1'b0;
            bus.long_press  <= 1'b0;
            bus.repeat_evt  <= 1'b0;
            bus.release_evt <= 1'b0;
            case (state)
                LOCK: begin
                    if (!bus.clean) state <= IDLE;
                end
                IDLE: begin
                    if (bus.clean) begin
                        state     <= PRESSED;
                        cnt       <= '0;
                        bus.press <= 1'b1;
                        bus.held  <= 1'b1;
                    end
                end
                PRESSED: begin
                    // Release wins over a long_press due on the same edge.
                    if (!bus.clean) begin
                        state            <= IDLE;
                        bus.release_evt  <= 1'b1;
                        bus.release_long <= 1'b0;
                        bus.held         <= 1'b0;
                    end else if (cnt == LONG_LAST) begin
                        state          <= LONG;
                        cnt            <= '0;
                        bus.long_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LONG: begin
                    if (!bus.clean) begin
                        state            <= IDLE;
                        bus.release_evt  <= 1'b1;
                        bus.release_long <= 1'b1;
                        bus.held         <= 1'b0;
                    end else if (cnt == REPEAT_LAST) begin
                        cnt            <= '0;
                        bus.repeat_evt <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= LOCK;
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Randomised and directed stimulus for key_event_decoder, checked by a scoreboard
// fed from a run-length reference model of the key behaviour.
module tb_key_event_decoder;

    localparam int unsigned L = 8;
    localparam int unsigned R = 4;

    typedef struct {
        int          cyc;
        logic [3:0]  ev;   // {press, long_press, repeat_evt, release_evt}
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    key_event_decoder_if bus ();

    key_event_decoder #(
        .LONG_CYCLES  (L),
        .REPEAT_CYCLES(R),
        .CNT_W        (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model state: lock flag, whether a press is tracked, and how many
    // edges the key has stayed down since the press edge.
    exp_t q[$];
    bit   locked = 1'b1;
    bit   pressing = 1'b0;
    int   hold_n = 0;
    logic exp_held = 1'b0;
    logic exp_rl = 1'b0;

    function automatic void check(string name, logic [7:0] act, logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endfunction

    task automatic push_ev(input logic [3:0] ev);
        exp_t e;
        e.cyc = cyc;
        e.ev  = ev;
        q.push_back(e);
    endtask

    task automatic model_edge(input logic c);
        if (locked) begin
            if (!c) locked = 1'b0;
        end else if (c) begin
            if (!pressing) begin
                pressing = 1'b1;
                hold_n   = 0;
                push_ev(4'b1000);
            end else begin
                hold_n++;
                if (hold_n == L) push_ev(4'b0100);
                else if (hold_n > L && ((hold_n - L) % R) == 0) push_ev(4'b0010);
            end
        end else if (pressing) begin
            pressing = 1'b0;
            exp_rl   = (hold_n >= L);
            push_ev(4'b0001);
        end
        exp_held = pressing;
    endtask

    task automatic step(input logic v);
        bus.clean = v;
        @(posedge clk);
        cyc++;
        if (rst) model_edge(v);
        #1;
    endtask

    task automatic run(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic do_reset(input logic v, input int n);
        rst      = 1'b0;
        locked   = 1'b1;
        pressing = 1'b0;
        exp_held = 1'b0;
        exp_rl   = 1'b0;
        q.delete();
        #1;
        check("rst_press",        {7'd0, bus.press},        8'd0);
        check("rst_long_press",   {7'd0, bus.long_press},   8'd0);
        check("rst_repeat_evt",   {7'd0, bus.repeat_evt},   8'd0);
        check("rst_release_evt",  {7'd0, bus.release_evt},  8'd0);
        check("rst_release_long", {7'd0, bus.release_long}, 8'd0);
        check("rst_held",         {7'd0, bus.held},         8'd0);
        run(v, n);
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        logic [3:0] act_ev;
        logic [3:0] req_ev;
        act_ev = {bus.press, bus.long_press, bus.repeat_evt, bus.release_evt};
        req_ev = 4'b0000;
        if (q.size() > 0 && q[0].cyc == cyc) req_ev = q.pop_front().ev;
        check("events", {4'd0, act_ev}, {4'd0, req_ev});
        check("held", {7'd0, bus.held}, {7'd0, exp_held});
        check("release_long", {7'd0, bus.release_long}, {7'd0, exp_rl});
    end

    initial begin
        bus.clean = 1'b0;
        #1;
        do_reset(1'b0, 2);

        // Short press, no long_press.
        run(1'b0, 2); run(1'b1, 3); run(1'b0, 3);
        // Long hold with two repeats.
        run(1'b1, 20); run(1'b0, 2);
        // Release on the edge where long_press would fire.
        run(1'b1, L); run(1'b0, 2);
        // Release on the edge where repeat_evt would fire.
        run(1'b1, L + R); run(1'b0, 2);
        // Key held through reset stays locked until released.
        run(1'b1, 3);
        do_reset(1'b1, 2);
        run(1'b1, 5); run(1'b0, 2); run(1'b1, 3); run(1'b0, 2);
        // Reset while in LONG.
        run(1'b1, L + 3);
        do_reset(1'b0, 2);
        run(1'b0, 1);
        // Back-to-back 1,0,1.
        step(1'b1); step(1'b0); step(1'b1); run(1'b0, 3);

        for (int i = 0; i < 40; i++) begin
            run(1'b1, int'($urandom_range(1, 22)));
            if ($urandom_range(0, 9) == 0) do_reset(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
            run(1'b0, int'($urandom_range(1, 4)));
        end
        run(1'b0, 3);

        check("queue_empty", 8'(q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Consumes the debounced, level-stable key signal from the front-panel debouncer and converts it into single-cycle key events for the scheduling control FSM: press, short/long release, long-press and auto-repeat. It sits directly behind each debounced button input. It suppresses any event for a key already held when reset is released.

## Interface
Parameters:
- LONG_CYCLES, 1000: hold length, in clk cycles after the press pulse, at which long_press fires. Must be ≥2 and < 2^CNT_W.
- REPEAT_CYCLES, 250: auto-repeat period while long-held. Must be ≥2 and < 2^CNT_W.
- CNT_W, 16: hold-counter width.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset; asynchronous assert, active-low.
- clean  input  1  debounced key level, 1 = pressed; synchronous to clk.
- press  output  1  one-cycle pulse on accepted 0→1 key transition.
- long_press  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- repeat_evt  output  1  one-cycle pulse every REPEAT_CYCLES while long-held.
- release_evt  output  1  one-cycle pulse on release of a tracked press.
- release_long  output  1  valid with release_evt: 1 if the release followed a long_press, else 0.
- held  output  1  high while state is PRESSED or LONG.

## Operation
- State machine LOCK, IDLE, PRESSED, LONG; counter cnt[CNT_W-1:0].
- All outputs are registered. Each event output is high for exactly one cycle.
- LOCK: entered on reset. An edge sampling clean=0 moves to IDLE. No events are produced in LOCK.
- IDLE: an edge sampling clean=1 moves to PRESSED, sets cnt←0 and press←1.
- PRESSED:
  - clean=0 → IDLE, release_evt←1, release_long←0.
  - Otherwise, if cnt==LONG_CYCLES-1 → LONG, cnt←0, long_press←1.
  - Otherwise cnt←cnt+1.
- LONG:
  - clean=0 → IDLE, release_evt←1, release_long←1.
  - Otherwise, if cnt==REPEAT_CYCLES-1 → cnt←0, repeat_evt←1.
  - Otherwise cnt←cnt+1.
- Release takes priority over long_press and repeat_evt on the same edge; the suppressed event is not produced.
- cnt never wraps. It is bounded by the two compare values.
- release_long holds its value until the next release_evt. Its reset value is 0.

## Timing
- Reset values: press, long_press, repeat_evt, release_evt, release_long, held all 0; state LOCK; cnt 0.
- Reset asserted mid-hold: all outputs drop to 0 immediately and asynchronously. No release_evt is issued. After deassertion the block stays in LOCK until clean=0 is sampled.
- press latency: high in the cycle after the first edge sampling clean=1 in IDLE.
- long_press: LONG_CYCLES cycles after the press pulse, provided clean stays 1 throughout.
- First repeat_evt: REPEAT_CYCLES cycles after long_press. Subsequent pulses are every REPEAT_CYCLES cycles.
- release_evt: the cycle after the first edge sampling clean=0 in PRESSED or LONG.
- held: same timing as press on rising, same timing as release_evt on falling.
- A one-cycle clean=1 glitch in IDLE produces press, then release_evt on the next cycle. No minimum hold is enforced; the debouncer guarantees stability.
- The minimum re-press gap is one cycle: IDLE accepts clean=1 on the edge after release.

## Structure
- Package key_event_pkg: enumerated state type (LOCK, IDLE, PRESSED, LONG) and default parameter constants.
- Single module. No sub-module; the counter and compares are inline.

## Test plan
Parameters for all scenarios: LONG_CYCLES=8, REPEAT_CYCLES=4.
- Reset with clean=0, then clean=1 held for 3 cycles → press 1 cycle after rise; release_evt 1 cycle after fall with release_long=0; no long_press.
- clean=1 held for 20 cycles → long_press 8 cycles after press; repeat_evt at +4 and +8 after long_press; release_evt with release_long=1.
- clean=0 on the same edge where cnt==7 in PRESSED → release_evt=1, release_long=0, no long_press. Repeat with cnt==3 in LONG → release_evt=1, release_long=1, no repeat_evt.
- clean=1 during and after reset → no press until clean goes 0 and then 1 again.
- Assert rst while in LONG → all outputs 0 immediately, no release_evt, state LOCK.
- Back-to-back: clean 1,0,1 on consecutive cycles → press, release_evt, press on consecutive cycles; each pulse exactly 1 cycle wide.
